// File: rtl/mux_rr_n_1.sv
// mux_rr_n_1 -- N:1 multiplexer with one registered output stage.
//
// Selects one of N valid/ready input channels and registers its word into a
// single output slot. The grant is either an external select (MODE=0) or a
// round-robin search starting just after the last granted channel (MODE=1).
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    N*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   N, per-channel valid
//   in_ready   N, per-channel accept (combinational, at most one bit set)
//   sel        SEL_W, channel select (MODE=0 only)
//   out_data   WIDTH, registered selected word
//   out_valid  out_data holds an unconsumed word
//   out_ready  downstream accept
//   out_ch     SEL_W, source channel of out_data

// Per-channel accept: a lane is ready only when it holds the grant and the
// output slot can take a word. Forced low during reset.
module mux_rr_lane #(
  parameter int IDX   = 0,
  parameter int SEL_W = 2
) (
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             grant_vld,
  input  logic [SEL_W-1:0] grant_idx,
  output logic             ready
);
  assign ready = rst_n && load_en && grant_vld && (grant_idx == SEL_W'(IDX));
endmodule

module mux_rr_n_1 #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  parameter  int MODE  = 1,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_ch
);

  logic [N-1:0][WIDTH-1:0] lane_data;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             xfer_in;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  int               cand;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane_data[i] = in_data[i*WIDTH +: WIDTH];

    mux_rr_lane #(.IDX(i), .SEL_W(SEL_W)) u_lane (
      .rst_n     (rst_n),
      .load_en   (load_en),
      .grant_vld (grant_vld),
      .grant_idx (grant_idx),
      .ready     (in_ready[i])
    );
  end

  // Slot can take a word when empty or when its word leaves this cycle.
  assign load_en = !out_valid_q || out_ready;
  // A grant always points at a valid channel, so grant + load_en is a transfer.
  assign xfer_in = grant_vld && load_en;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (MODE == 0) begin
      // Out-of-range select (non power-of-2 N) grants nothing.
      if (int'(sel) < N && in_valid[sel]) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end else begin
      // Search ptr+1, ptr+2, ... wrapping at N; ptr itself is checked last.
      for (int k = 1; k <= N; k++) begin
        cand = int'(ptr_q) + k;
        if (cand >= N) cand = cand - N;
        if (!grant_vld && in_valid[SEL_W'(cand)]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(cand);
        end
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_in) begin
      out_data_d  = lane_data[grant_idx];
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (MODE != 0) ptr_d = grant_idx;
    end else if (load_en) begin
      // Drained (or already empty) with nothing new: data/ch keep last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      // Pointer at N-1 gives channel 0 first priority after reset.
      ptr_q       <= SEL_W'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_n_1.sv
// Bench for mux_rr_n_1: two instances (round-robin and external select) share
// clock, reset, data, sel and out_ready. A reference model predicts grants and
// pushes expected words into per-instance queues; a monitor pops on each
// output transfer and compares.
module tb_mux_rr_n_1;
  localparam int W = 8;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   ch;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   iv_rr, iv_sel;
  logic [1:0]     sel;
  logic           out_ready;

  logic [N-1:0]   rdy_rr, rdy_sel;
  logic [W-1:0]   od_rr, od_sel;
  logic           ov_rr, ov_sel;
  logic [1:0]     oc_rr, oc_sel;

  always #5 clk = ~clk;

  mux_rr_n_1 #(.WIDTH(W), .N(N), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv_rr),
    .in_ready(rdy_rr), .sel(sel), .out_data(od_rr), .out_valid(ov_rr),
    .out_ready(out_ready), .out_ch(oc_rr)
  );

  mux_rr_n_1 #(.WIDTH(W), .N(N), .MODE(0)) u_sel (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv_sel),
    .in_ready(rdy_sel), .sel(sel), .out_data(od_sel), .out_valid(ov_sel),
    .out_ready(out_ready), .out_ch(oc_sel)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int u, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t: got %0h want %0h", nm, u, $time, act, exp);
    end
  endtask

  // Spec-level grant rule: -1 means no grant.
  function automatic int grant_of(input int mode, input int ptr,
                                  input logic [N-1:0] iv, input int s);
    if (mode == 0) return (s < N && iv[s]) ? s : -1;
    for (int k = 1; k <= N; k++)
      if (iv[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] lane(input int i);
    return in_data[i*W +: W];
  endfunction

  // ---------------- reference model ----------------
  exp_t       q_rr[$];
  exp_t       q_sel[$];
  int         m_ptr [2];
  logic       m_vld [2];
  logic [W-1:0] m_dat [2];
  logic [1:0] m_ch  [2];
  bit         started = 0;

  logic [N-1:0] t_iv, t_rdy;
  logic         t_ov;
  logic [W-1:0] t_od;
  logic [1:0]   t_oc;
  logic         le;
  int           g;

  always @(negedge clk) begin
    #2;
    for (int u = 0; u < 2; u++) begin
      t_iv  = (u == 0) ? iv_rr  : iv_sel;
      t_rdy = (u == 0) ? rdy_rr : rdy_sel;
      t_ov  = (u == 0) ? ov_rr  : ov_sel;
      t_od  = (u == 0) ? od_rr  : od_sel;
      t_oc  = (u == 0) ? oc_rr  : oc_sel;
      if (!rst_n) begin
        check("ready_in_reset", u, 32'(t_rdy), 32'd0);
        if (u == 0) q_rr.delete(); else q_sel.delete();
        m_vld[u] = 1'b0;
        m_dat[u] = '0;
        m_ch[u]  = '0;
        m_ptr[u] = N - 1;
        started  = 1;
      end else if (started) begin
        check("out_valid", u, 32'(t_ov), 32'(m_vld[u]));
        check("out_data",  u, 32'(t_od), 32'(m_dat[u]));
        check("out_ch",    u, 32'(t_oc), 32'(m_ch[u]));
        le = !m_vld[u] || out_ready;
        g  = grant_of((u == 0) ? 1 : 0, m_ptr[u], t_iv, int'(sel));
        check("in_ready", u, 32'(t_rdy), (g >= 0 && le) ? (32'd1 << g) : 32'd0);
        if (g >= 0 && le) begin
          if (u == 0) q_rr.push_back('{lane(g), 2'(g)});
          else        q_sel.push_back('{lane(g), 2'(g)});
          m_vld[u] = 1'b1;
          m_dat[u] = lane(g);
          m_ch[u]  = 2'(g);
          m_ptr[u] = g;
        end else if (le) begin
          m_vld[u] = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic         p_hold [2] = '{1'b0, 1'b0};
  logic [W-1:0] p_dat  [2];
  logic [1:0]   p_ch   [2];
  exp_t         e;
  logic         mv;
  logic [W-1:0] md;
  logic [1:0]   mc;
  bit           empty;

  always @(negedge clk) begin
    #2;
    for (int u = 0; u < 2; u++) begin
      mv = (u == 0) ? ov_rr : ov_sel;
      md = (u == 0) ? od_rr : od_sel;
      mc = (u == 0) ? oc_rr : oc_sel;
      if (rst_n && started) begin
        if (p_hold[u]) begin
          check("stall_valid", u, 32'(mv), 32'd1);
          check("stall_data",  u, 32'(md), 32'(p_dat[u]));
          check("stall_ch",    u, 32'(mc), 32'(p_ch[u]));
        end
        if (mv && out_ready) begin
          empty = (u == 0) ? (q_rr.size() == 0) : (q_sel.size() == 0);
          if (empty) begin
            total++;
            bad++;
            $display("FAIL pop_empty inst%0d t=%0t: got word %0h want none", u, $time, md);
          end else begin
            e = (u == 0) ? q_rr.pop_front() : q_sel.pop_front();
            check("sb_data", u, 32'(md), 32'(e.d));
            check("sb_ch",   u, 32'(mc), 32'(e.ch));
          end
        end
        p_hold[u] = mv && !out_ready;
        p_dat[u]  = md;
        p_ch[u]   = mc;
      end else begin
        p_hold[u] = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic [N-1:0] vr, input logic [N-1:0] vs,
                     input logic ordy, input logic [1:0] s, input logic [31:0] d);
    @(negedge clk);
    rst_n = r; iv_rr = vr; iv_sel = vs; out_ready = ordy; sel = s; in_data = d;
  endtask

  initial begin
    rst_n = 1'b0; iv_rr = '1; iv_sel = '1; out_ready = 1'b1; sel = 2'd0;
    in_data = 32'hA3A2A1A0;
    // reset held over two edges with every channel requesting
    cyc(0, 4'hF, 4'hF, 1, 0, 32'hA3A2A1A0);
    // round-robin fairness: 0,1,2,3,0,...
    repeat (10) cyc(1, 4'hF, 4'hF, 1, 0, 32'hA3A2A1A0);
    // sparse requests on channels 0 and 2
    repeat (6) cyc(1, 4'b0101, 4'b0101, 1, 2, 32'hB3B2B1B0);
    // backpressure with a 55 word held
    cyc(1, 4'hF, 4'hF, 1, 0, 32'h55555555);
    repeat (3) cyc(1, 4'hF, 4'hF, 0, 1, 32'h66666666);
    repeat (2) cyc(1, 4'hF, 4'hF, 1, 1, 32'h77777777);
    // external select: sel=3, then sel=1 with channel 1 idle
    repeat (5) cyc(1, 4'hF, 4'hF, 1, 3, 32'hC3C2C1C0);
    repeat (3) cyc(1, 4'hF, 4'b1101, 1, 1, 32'hD3D2D1D0);
    // sel change while stalled only affects the next grant
    cyc(1, 4'hF, 4'hF, 1, 3, 32'hE3E2E1E0);
    repeat (2) cyc(1, 4'hF, 4'hF, 0, 2, 32'hF3F2F1F0);
    cyc(1, 4'hF, 4'hF, 1, 0, 32'h13121110);
    // mid-operation reset with a held word
    cyc(1, 4'hF, 4'hF, 0, 2, 32'h23222120);
    cyc(0, 4'hF, 4'hF, 0, 2, 32'h33323130);
    repeat (3) cyc(1, 4'h0, 4'h0, 1, 0, 32'h43424140);
    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) != 0), 4'($urandom), 4'($urandom),
          ($urandom_range(0, 3) != 0), 2'($urandom), $urandom);
    // drain
    repeat (4) cyc(1, 4'h0, 4'h0, 1, 0, 32'h0);
    @(negedge clk);
    #4;
    check("drain_q", 0, 32'(q_rr.size()), 32'd0);
    check("drain_q", 1, 32'(q_sel.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_n_1.md
MUX_RR_N_1 -- requirements
Module: mux_rr_n_1

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width per channel in bits (1..64).
REQ-002 SHALL have parameter N, default 4, meaning input channel count (2..16).
REQ-003 SHALL have parameter MODE, default 1, meaning 0 = external select, 1 = round-robin arbitration.
REQ-004 SHALL have localparam SEL_W, derived as clog2(N), meaning select/channel-index width.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, meaning synchronous active-low reset.
REQ-007 SHALL have port in_data, input, N*WIDTH bits, meaning channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid, input, N bits, meaning per-channel data valid.
REQ-009 SHALL have port in_ready, output, N bits, meaning per-channel accept; combinational.
REQ-010 SHALL have port sel, input, SEL_W bits, meaning channel select; used only when MODE=0.
REQ-011 SHALL have port out_data, output, WIDTH bits, meaning registered selected data.
REQ-012 SHALL have port out_valid, output, 1 bit, meaning out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready, input, 1 bit, meaning downstream accept.
REQ-014 SHALL have port out_ch, output, SEL_W bits, meaning source channel index of out_data.

Function
REQ-015 SHALL contain one output register stage (out_data, out_ch, out_valid); input-to-output latency is exactly 1 cycle.
REQ-016 SHALL define load_en = !out_valid || out_ready; the stage accepts a new word only when load_en=1.
REQ-017 SHALL assert at most one in_ready bit per cycle: in_ready[g]=load_en for the granted channel g, all other bits 0.
REQ-018 SHALL define an input transfer on channel i as in_valid[i] && in_ready[i]; an output transfer as out_valid && out_ready.
REQ-019 MODE=0: SHALL set grant g=sel when in_valid[sel]=1; when sel >= N (N not a power of 2), SHALL grant nothing.
REQ-020 MODE=1: SHALL search for the first channel with in_valid=1 in the order ptr+1, ptr+2, ... modulo N, wrapping from N-1 to 0.
REQ-021 MODE=1: SHALL update ptr to the granted index only on an input transfer; ptr SHALL hold otherwise.
REQ-022 SHALL, on an input transfer, load out_data=in_data of g, out_ch=g and out_valid=1 at the next edge.
REQ-023 SHALL clear out_valid when an output transfer occurs without an input transfer in the same cycle.
REQ-024 SHALL, when an output transfer and an input transfer occur in the same cycle, load the new word with out_valid held at 1, sustaining 1 word/cycle throughput.
REQ-025 SHALL hold out_data and out_ch stable while out_valid=1 and out_ready=0 (backpressure); no in_ready is asserted in that state.
REQ-026 SHALL leave out_valid=0 and out_data unchanged when no in_valid bit is set and load_en=1.
REQ-027 SHALL drop no word and duplicate no word: each input transfer produces exactly one output transfer.
REQ-028 SHALL treat a sel change (MODE=0) while stalled as affecting only the next grant, never the held output.

Reset
REQ-029 SHALL, while rst_n=0 at a rising clk edge, set out_valid=0, out_data=0, out_ch=0 and ptr=N-1, so channel 0 has first priority after reset.
REQ-030 SHALL hold in_ready all-zero while rst_n=0.
REQ-031 SHALL discard any held word when reset is asserted mid-operation; no output transfer of that word occurs after reset release.

Verification
REQ-032 Reset: rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0; after release, first grant is channel 0.
REQ-033 Round-robin fairness (N=4, MODE=1, all in_valid=1, out_ready=1, in_data ch i = 8'hA0+i) -> out_ch sequence 0,1,2,3,0,... and out_data A0,A1,A2,A3,A0, one word per cycle.
REQ-034 Sparse request (only in_valid[2] and in_valid[0], ptr=2) -> grant order 0 then 2; ptr wraps through index 3 correctly.
REQ-035 Backpressure: out_ready=0 for 3 cycles with a word held (out_data=8'h55) -> out_data stays 55, out_valid=1, in_ready=0; on out_ready=1 the next word loads the same cycle.
REQ-036 MODE=0: sel=3, in_valid=4'b1111 -> only in_ready[3] asserted; out_ch=3 every cycle; sel=1 with in_valid[1]=0 -> no transfer, out_valid falls after drain.
REQ-037 Mid-operation reset: assert rst_n=0 while out_valid=1, out_ready=0 -> the held word is discarded (out_valid=0) and is never output after release.
